// File: rtl/seq_mac_pkg.sv
// Shared constants, state encoding and width helper for the sequential MAC engine.
package seq_mac_pkg;

    localparam logic [1:0] MODE_MUL = 2'd0;
    localparam logic [1:0] MODE_MAC = 2'd1;
    localparam logic [1:0] MODE_CLR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Accumulator width: full product plus guard bits.
    function automatic int calc_acc_w(input int data_w, input int acc_extra);
        return 2 * data_w + acc_extra;
    endfunction

endpackage

// File: rtl/seq_mul_core.sv
// Unsigned shift-add multiplier: one partial-product step per cycle, DATA_W steps per product.
module seq_mul_core
    import seq_mac_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   product
);

    logic [DATA_W-1:0] mcand;
    // Upper half carries one extra bit for the add; multiplier sits in the low half
    // and is consumed LSB first as the whole register shifts right.
    logic [2*DATA_W:0] p;
    logic [DATA_W:0]   upper;

    // Conditional add of the multiplicand into the upper half.
    always_comb begin
        upper = p[2*DATA_W:DATA_W] + (p[0] ? {1'b0, mcand} : '0);
    end

    // Operand load and per-cycle shift-add step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand <= '0;
            p     <= '0;
        end else if (load) begin
            mcand <= a;
            p     <= {(DATA_W + 1)'(0), b};
        end else if (step) begin
            p     <= {upper, p[DATA_W-1:0]} >> 1;
        end
    end

    assign product = p[2*DATA_W-1:0];

endmodule

// File: rtl/seq_mac_engine.sv
// Start/done iterative multiply-accumulate engine with signed mode and sticky overflow.
module seq_mac_engine
    import seq_mac_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int SIGNED    = 0,
    parameter  int ACC_EXTRA = 4,
    localparam int ACC_W     = calc_acc_w(DATA_W, ACC_EXTRA)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] din_a,
    input  logic [DATA_W-1:0] din_b,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  dout,
    output logic              ovf
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t               state;
    logic [1:0]           mode_r;
    logic                 neg_r;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_W-1:0]    mag_a;
    logic [DATA_W-1:0]    mag_b;
    logic                 load;
    logic [2*DATA_W-1:0]  product;
    logic [ACC_W-1:0]     prod_ext;
    logic [ACC_W:0]       sum;
    logic                 mac_ovf;

    // Operand magnitudes; -2^(DATA_W-1) negates to itself, which reads correctly as unsigned.
    always_comb begin
        mag_a = din_a;
        mag_b = din_b;
        if (SIGNED != 0) begin
            if (din_a[DATA_W-1]) mag_a = -din_a;
            if (din_b[DATA_W-1]) mag_b = -din_b;
        end
    end

    assign load = (state == ST_IDLE) && start && (mode != MODE_CLR);

    seq_mul_core #(.DATA_W(DATA_W)) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (state == ST_RUN),
        .a       (mag_a),
        .b       (mag_b),
        .product (product)
    );

    // Extend the product to accumulator width and restore the sign; the magnitude
    // never exceeds 2^(2*DATA_W-2) in signed mode so negation is exact.
    always_comb begin
        prod_ext = ACC_W'(product);
        if (neg_r) prod_ext = -prod_ext;
        sum      = {1'b0, dout} + {1'b0, prod_ext};
        if (SIGNED != 0)
            mac_ovf = (dout[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != dout[ACC_W-1]);
        else
            mac_ovf = sum[ACC_W];
    end

    // Control FSM with registered busy/done and result update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            mode_r <= MODE_MUL;
            neg_r  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dout   <= '0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        busy   <= 1'b1;
                        if (mode == MODE_CLR) begin
                            state <= ST_FINISH;
                        end else begin
                            neg_r <= (SIGNED != 0) && (din_a[DATA_W-1] ^ din_b[DATA_W-1]);
                            cnt   <= '0;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) state <= ST_FINISH;
                end
                ST_FINISH: begin
                    case (mode_r)
                        MODE_CLR: begin
                            dout <= '0;
                            ovf  <= 1'b0;
                        end
                        MODE_MAC: begin
                            dout <= sum[ACC_W-1:0];
                            ovf  <= ovf | mac_ovf;
                        end
                        default: dout <= prod_ext;
                    endcase
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mac_engine.sv
// Self-checking bench: unsigned and signed instances driven in lockstep against an arithmetic model.
module tb_seq_mac_engine;
    import seq_mac_pkg::*;

    localparam int DW = 8;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] din_a = '0;
    logic [DW-1:0] din_b = '0;
    logic          busy_u, done_u, ovf_u;
    logic          busy_s, done_s, ovf_s;
    logic [AW-1:0] dout_u, dout_s;

    int checks = 0;
    int failures = 0;

    // reference state: accumulator as plain integers
    longint acc_u = 0, acc_s = 0;
    bit     rovf_u = 0, rovf_s = 0;

    always #5 clk = ~clk;

    seq_mac_engine #(.DATA_W(DW), .SIGNED(0), .ACC_EXTRA(4)) dut_u (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .din_a(din_a), .din_b(din_b),
        .busy(busy_u), .done(done_u), .dout(dout_u), .ovf(ovf_u));

    seq_mac_engine #(.DATA_W(DW), .SIGNED(1), .ACC_EXTRA(4)) dut_s (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .din_a(din_a), .din_b(din_b),
        .busy(busy_s), .done(done_s), .dout(dout_s), .ovf(ovf_s));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint pu = longint'(a) * longint'(b);
        longint ps = longint'($signed(a)) * longint'($signed(b));
        case (m)
            MODE_CLR: begin
                acc_u = 0; acc_s = 0; rovf_u = 0; rovf_s = 0;
            end
            MODE_MAC: begin
                acc_u = acc_u + pu;
                if (acc_u >= (64'sd1 << AW)) begin rovf_u = 1; acc_u -= (64'sd1 << AW); end
                acc_s = acc_s + ps;
                if (acc_s > (64'sd1 << (AW-1)) - 1) begin rovf_s = 1; acc_s -= (64'sd1 << AW); end
                else if (acc_s < -(64'sd1 << (AW-1))) begin rovf_s = 1; acc_s += (64'sd1 << AW); end
            end
            default: begin
                acc_u = pu; acc_s = ps;
            end
        endcase
    endfunction

    function automatic logic [63:0] exp20(input longint v);
        logic [AW-1:0] t = AW'(v);
        return 64'(t);
    endfunction

    // Issue one operation, optionally re-pulsing start at cycle 'poke' while busy.
    // Cycle k is the clock period that ends at the k-th rising edge after the sampling edge.
    task automatic do_op(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b, input int poke);
        int n = 0, bc = 0, lat;
        bit got = 0;
        lat = (m == MODE_CLR) ? 2 : DW + 2;
        @(negedge clk);
        start = 1'b1; mode = m; din_a = a; din_b = b;
        model(m, a, b);
        @(posedge clk);
        #1;
        start = 1'b0; mode = 2'($urandom); din_a = 8'($urandom); din_b = 8'($urandom);
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            start = (n == poke);
            if (n == poke) begin
                mode = MODE_MUL; din_a = 8'($urandom); din_b = 8'($urandom);
            end
            if (busy_u) bc++;
            if (done_u) got = 1;
        end
        start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        chk("latency", 64'(n), 64'(lat));
        chk("busy_cycles", 64'(bc), 64'(lat - 1));
        chk("busy_at_done", 64'(busy_u), 64'd0);
        chk("done_s", 64'(done_s), 64'd1);
        chk("dout_u", 64'(dout_u), exp20(acc_u));
        chk("ovf_u", 64'(ovf_u), 64'(rovf_u));
        chk("dout_s", 64'(dout_s), exp20(acc_s));
        chk("ovf_s", 64'(ovf_s), 64'(rovf_s));
    endtask

    task automatic count_dones(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_u || done_s) nd++;
        end
    endtask

    initial begin
        int nd, n1, n2;
        // reset state
        #2;
        chk("rst_busy", 64'(busy_u), 64'd0);
        chk("rst_done", 64'(done_u), 64'd0);
        chk("rst_dout", 64'(dout_u), 64'd0);
        chk("rst_ovf", 64'(ovf_u), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // basic unsigned multiplies
        do_op(MODE_MUL, 8'd15, 8'd15, 0);
        chk("mul_15x15", 64'(dout_u), 64'd225);
        do_op(MODE_MUL, 8'd255, 8'd255, 0);
        chk("mul_255x255", 64'(dout_u), 64'd65025);

        // accumulate into overflow
        do_op(MODE_CLR, 8'd0, 8'd0, 0);
        for (int i = 0; i < 16; i++) do_op(MODE_MAC, 8'd255, 8'd255, 0);
        chk("mac16_dout", 64'(dout_u), 64'd1040400);
        chk("mac16_ovf", 64'(ovf_u), 64'd0);
        do_op(MODE_MAC, 8'd255, 8'd255, 0);
        chk("mac17_dout", 64'(dout_u), 64'd56849);
        chk("mac17_ovf", 64'(ovf_u), 64'd1);
        do_op(MODE_MUL, 8'd1, 8'd1, 0);
        chk("mul_after_ovf", 64'(dout_u), 64'd1);
        chk("ovf_sticky", 64'(ovf_u), 64'd1);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; mode = MODE_MUL; din_a = 8'd200; din_b = 8'd100;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_u), 64'd0);
        chk("arst_dout", 64'(dout_u), 64'd0);
        chk("arst_ovf", 64'(ovf_u), 64'd0);
        chk("arst_busy_s", 64'(busy_s), 64'd0);
        chk("arst_dout_s", 64'(dout_s), 64'd0);
        acc_u = 0; acc_s = 0; rovf_u = 0; rovf_s = 0;
        @(negedge clk);
        reset = 1'b1;
        count_dones(15, nd);
        chk("no_done_after_rst", 64'(nd), 64'd0);
        do_op(MODE_MUL, 8'd7, 8'd9, 0);
        chk("mul_7x9", 64'(dout_u), 64'd63);

        // overflow again, then CLR must clear it
        for (int i = 0; i < 17; i++) do_op(MODE_MAC, 8'd255, 8'd255, 0);
        chk("ovf_reset_again", 64'(ovf_u), 64'd1);
        do_op(MODE_CLR, 8'd33, 8'd44, 0);
        chk("clr_dout", 64'(dout_u), 64'd0);
        chk("clr_ovf", 64'(ovf_u), 64'd0);

        // signed directed cases
        do_op(MODE_MUL, 8'hFD, 8'd5, 0);
        chk("s_m3x5", 64'(dout_s), 64'h0FFFF1);
        do_op(MODE_MUL, 8'h80, 8'h80, 0);
        chk("s_m128xm128", 64'(dout_s), 64'd16384);
        do_op(MODE_MUL, 8'h80, 8'h7F, 0);
        chk("s_m128x127", 64'(dout_s), 64'h0FC080);

        // reserved mode acts as MUL
        do_op(2'd3, 8'd12, 8'd11, 0);
        chk("mode3_mul", 64'(dout_u), 64'd132);

        // start pulse while busy is dropped, not queued
        do_op(MODE_MUL, 8'd21, 8'd3, 3);
        chk("poke_result", 64'(dout_u), 64'd63);
        count_dones(14, nd);
        chk("poke_no_extra_done", 64'(nd), 64'd0);

        // start held high: restarts on each done cycle
        @(negedge clk);
        start = 1'b1; mode = MODE_MUL; din_a = 8'd6; din_b = 8'd7;
        model(MODE_MUL, 8'd6, 8'd7);
        n1 = 0;
        while (n1 < 40 && !done_u) begin @(negedge clk); n1++; end
        n2 = 0;
        do begin @(negedge clk); n2++; end while (n2 < 40 && !done_u);
        start = 1'b0;
        chk("held_first", 64'(n1), 64'd10);
        chk("held_second", 64'(n2), 64'd10);
        chk("held_dout", 64'(dout_u), 64'd42);
        count_dones(14, nd);
        chk("held_stop", 64'(nd), 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 40; i++)
            do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_mac_engine.md
Name: seq_mac_engine

Overview:
- Parametrised start/done iterative multiply-accumulate engine for the lab designs; successor to the fixed 8-bit start/din/done/dout design block.
- Adds two-operand input, signed mode, generic width, accumulate/clear modes, a busy flag and a sticky overflow flag.
- Sits behind a simple controller or FSM and is exercised by a self-checking testbench.

Parameters:
- DATA_W, 8, operand width in bits (≥2).
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands.
- ACC_EXTRA, 4, guard bits in the accumulator.
- ACC_W (local), 2*DATA_W+ACC_EXTRA, accumulator/dout width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to clk externally.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  0 = MUL, 1 = MAC, 2 = CLR, 3 = reserved (treated as MUL); sampled with start.
- din_a  in  DATA_W  operand A, sampled with start.
- din_b  in  DATA_W  operand B, sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when dout is updated.
- dout  out  ACC_W  result/accumulator, held between operations.
- ovf  out  1  sticky accumulator overflow.

Behaviour:
- Reset (async on reset=0): state=IDLE; busy=0, done=0, dout=0, ovf=0; all internal registers cleared. Reset mid-operation aborts immediately and leaves no pending done.
- FSM states:
  - IDLE: start=1 captures operands and mode. CLR goes to FINISH; MUL/MAC go to RUN with cnt=0.
  - RUN: one shift-add step per cycle for exactly DATA_W cycles (cnt 0..DATA_W-1), then goes to FINISH.
  - FINISH: updates dout, pulses done, returns to IDLE.
- busy=1 in RUN and FINISH. done=1 only in the cycle after FINISH, registered together with dout.
- Latency:
  - MUL/MAC: start sampled at edge E0 → done high during cycle E0+DATA_W+2, which is also the first cycle dout is valid. For DATA_W=8, that is 10 cycles after the sampling edge.
  - CLR: done 2 cycles after E0.
- Back-to-back: a new start is accepted in the cycle done is high (state is IDLE then). start while busy=1 is ignored and not queued.
- Signed mode (SIGNED=1):
  - Magnitudes |a| and |b| are taken at capture. |−2^(DATA_W−1)| is held as a DATA_W-bit unsigned value, so no overflow occurs.
  - An unsigned shift-add product is computed, then negated in FINISH when sign(a) XOR sign(b).
  - The product is sign-extended to ACC_W.
- Unsigned mode: the product is zero-extended to ACC_W.
- MUL: dout ← product. ovf is unchanged.
- MAC: dout ← dout + product, mod 2^ACC_W (wrap-around).
  - ovf set if the unsigned carry out of ACC_W occurs (SIGNED=0), or on signed overflow (SIGNED=1).
  - ovf is never cleared except by reset or CLR.
- CLR: dout ← 0, ovf ← 0; operands are ignored.
- Operand changes after capture have no effect on the current operation.

Decomposition:
- Package seq_mac_pkg holds:
  - mode constants MODE_MUL=2'd0, MODE_MAC=2'd1, MODE_CLR=2'd2;
  - state encodings ST_IDLE, ST_RUN, ST_FINISH;
  - an ACC_W computation function.
- One sub-module, seq_mul_core: the DATA_W-step unsigned shift-add datapath with load/step inputs and a 2*DATA_W product output.
- The top level holds the FSM, sign handling, accumulator and ovf logic.

Test Plan:
1. DATA_W=8, SIGNED=0, MUL, a=15, b=15 → done exactly 10 cycles after the sampling edge, dout=225, ovf=0, busy high for 9 cycles. Then a=255, b=255 → dout=65025.
2. MAC 255×255 issued 17 times after CLR (ACC_W=20) → after the 16th, dout=1040400 and ovf=0. After the 17th, dout=56849 (1105425 mod 2^20) and ovf=1. A following MUL 1×1 gives dout=1 with ovf still 1. CLR → dout=0, ovf=0, done 2 cycles after start.
3. SIGNED=1: (−3)×5 → dout=20'hFFFF1. (−128)×(−128) → 16384. (−128)×127 → −16256 (20'hFC080).
4. start pulsed again while busy, with different operands, during RUN → ignored: exactly one done, with the first result. A start held high continuously → a new operation begins on each done cycle.
5. reset driven low mid-RUN (cycle 4 of 8) → busy, done, dout and ovf go to 0 immediately (asynchronously). After release, no done appears until a new start, and the next MUL 7×9 gives 63.
6. Operands changed on the cycle after start → the result reflects the captured values. mode=3 behaves as MUL.
